// File: rtl/spi_slave_fifo.sv
`timescale 1ns/1ps
// SPI slave with DATA_W-bit words, any CPOL/CPHA, TX/RX FIFOs and sticky error
// flags. SCLK/CS_N/MOSI are oversampled in the CLK domain.
module spi_slave_fifo_buf #(
  parameter int  W     = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [AW:0]  level
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  // Push+pop is legal on full and on empty; an empty FIFO passes din straight through.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & (~empty | push);
  assign dout    = empty ? din : mem_q[rd_q];
  assign level   = cnt_q;

  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end
endmodule

module spi_slave_fifo #(
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 16,
  parameter bit              CPOL       = 1'b0,
  parameter bit              CPHA       = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '1,
  localparam int             LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] TX_DIN,
  input  logic              TX_VLD,
  output logic              TX_RDY,
  output logic [DATA_W-1:0] RX_DOUT,
  output logic              RX_VLD,
  input  logic              RX_RDY,
  output logic [LW-1:0]     TX_LEVEL,
  output logic [LW-1:0]     RX_LEVEL,
  output logic              RX_OVF,
  output logic              TX_UDF,
  input  logic              CLR_ERR
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  // [0],[1] synchroniser, [2] history for edge detection
  logic [2:0] sclk_q, sclk_d, csn_q, csn_d;
  logic [1:0] mosi_q, mosi_d;
  logic       rx_ovf_q, rx_ovf_d, tx_udf_q, tx_udf_d;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic [DATA_W-2:0]   rx_sh_q;
  logic                miso_q, oe_q;

  logic sclk_rise, sclk_fall, lead_e, trail_e, sample_e, shift_e;
  logic cs_fall, cs_rise, mosi_s, word_done;
  logic tx_push, tx_pop, rx_push, rx_pop, udf_evt, ovf_evt;
  logic [DATA_W-1:0] tx_dout, tx_word, rx_word, rx_dout;

  always_comb begin
    sclk_d = {sclk_q[1:0], SCLK};
    csn_d  = {csn_q[1:0], CS_N};
    mosi_d = {mosi_q[0], MOSI};
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign lead_e    = CPOL ? sclk_fall : sclk_rise;
  assign trail_e   = CPOL ? sclk_rise : sclk_fall;
  assign sample_e  = CPHA ? trail_e : lead_e;
  assign shift_e   = CPHA ? lead_e : trail_e;
  assign cs_fall   = ~csn_q[1] & csn_q[2];
  assign cs_rise   = csn_q[1] & ~csn_q[2];
  assign mosi_s    = mosi_q[1];

  assign word_done = (state_q == SHIFT) & ~cs_rise & sample_e & (cnt_q == CW'(DATA_W - 1));
  assign tx_push   = TX_VLD & TX_RDY;
  assign tx_pop    = ((state_q == LOAD) & ~cs_rise) | word_done;
  assign udf_evt   = tx_pop & (TX_LEVEL == '0) & ~tx_push;
  assign tx_word   = udf_evt ? IDLE_WORD : tx_dout;
  assign rx_word   = {rx_sh_q, mosi_s};
  assign rx_push   = word_done;
  assign rx_pop    = RX_VLD & RX_RDY;
  assign ovf_evt   = rx_push & (RX_LEVEL == LW'(FIFO_DEPTH)) & ~rx_pop;

  // Clear only wins over an old error; a new event in the same cycle keeps the flag.
  always_comb begin
    rx_ovf_d = (rx_ovf_q & ~CLR_ERR) | ovf_evt;
    tx_udf_d = (tx_udf_q & ~CLR_ERR) | udf_evt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_q   <= {3{CPOL}};
      csn_q    <= '1;
      mosi_q   <= '0;
      rx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
    end else begin
      sclk_q   <= sclk_d;
      csn_q    <= csn_d;
      mosi_q   <= mosi_d;
      rx_ovf_q <= rx_ovf_d;
      tx_udf_q <= tx_udf_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else if (cs_rise) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= LOAD;
            oe_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          tx_sh_q <= tx_word;
          cnt_q   <= '0;
          if (!CPHA) miso_q <= tx_word[DATA_W-1];
        end
        SHIFT: begin
          if (sample_e) begin
            rx_sh_q <= rx_word[DATA_W-2:0];
            if (word_done) begin
              cnt_q   <= '0;
              tx_sh_q <= tx_word;
              if (!CPHA) miso_q <= tx_word[DATA_W-1];
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (shift_e) begin
            // A shift edge at count 0 is the word boundary: CPHA=1 presents the MSB,
            // CPHA=0 already shows it and must not shift it away.
            if (cnt_q == '0) begin
              if (CPHA) miso_q <= tx_sh_q[DATA_W-1];
            end else begin
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              miso_q  <= tx_sh_q[DATA_W-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(RST_N), .push(tx_push), .din(TX_DIN), .pop(tx_pop),
    .dout(tx_dout), .level(TX_LEVEL)
  );

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(RST_N), .push(rx_push), .din(rx_word), .pop(rx_pop),
    .dout(rx_dout), .level(RX_LEVEL)
  );

  assign TX_RDY  = (TX_LEVEL != LW'(FIFO_DEPTH));
  assign RX_VLD  = (RX_LEVEL != '0);
  assign RX_DOUT = RX_VLD ? rx_dout : '0;
  assign MISO    = miso_q;
  assign MISO_OE = oe_q;
  assign RX_OVF  = rx_ovf_q;
  assign TX_UDF  = tx_udf_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
// Bench for spi_slave_fifo: one instance per SPI mode, a bit-banged master and
// scoreboard queues for the words the master and the RX FIFO should deliver.
module tb_spi_slave_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LW = 5;
  localparam int TH = 60;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] sclk, cs_n, mosi, miso, miso_oe, tx_vld, tx_rdy, rx_vld, rx_rdy, clr_err;
  logic [3:0] rx_ovf, tx_udf;
  logic [3:0][DW-1:0] tx_din, rx_dout;
  logic [3:0][LW-1:0] tx_level, rx_level;

  logic [7:0] exp_mi[$];
  logic [7:0] exp_rx[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CPOL(m >= 2), .CPHA(m % 2 == 1)) u_dut (
      .CLK(clk), .RST_N(rst_n), .SCLK(sclk[m]), .CS_N(cs_n[m]), .MOSI(mosi[m]),
      .MISO(miso[m]), .MISO_OE(miso_oe[m]), .TX_DIN(tx_din[m]), .TX_VLD(tx_vld[m]),
      .TX_RDY(tx_rdy[m]), .RX_DOUT(rx_dout[m]), .RX_VLD(rx_vld[m]), .RX_RDY(rx_rdy[m]),
      .TX_LEVEL(tx_level[m]), .RX_LEVEL(rx_level[m]), .RX_OVF(rx_ovf[m]),
      .TX_UDF(tx_udf[m]), .CLR_ERR(clr_err[m])
    );
  end

  task automatic push_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    tx_din[m] = d;
    tx_vld[m] = 1'b1;
    @(negedge clk);
    tx_vld[m] = 1'b0;
    exp_mi.push_back(d);
  endtask

  task automatic pulse_clr(input int m);
    @(negedge clk);
    clr_err[m] = 1'b1;
    @(negedge clk);
    clr_err[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    #(120);
  endtask

  task automatic cs_high(input int m);
    #(TH);
    cs_n[m] = 1'b1;
    #(200);
  endtask

  // Master: CPHA=0 drives before the leading edge and samples on it,
  // CPHA=1 drives on the leading edge and samples on the trailing edge.
  task automatic xfer(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi[m] = mo[7-i];
        #(TH);
        sclk[m] = ~cpol;
        mi[7-i] = miso[m];
        #(TH);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = mo[7-i];
        #(TH);
        sclk[m] = cpol;
        mi[7-i] = miso[m];
        #(TH);
      end
    end
  endtask

  task automatic spi_word(input int m, input logic [7:0] mo);
    logic [7:0] mi, e;
    xfer(m, mo, 8, mi);
    e = (exp_mi.size() > 0) ? exp_mi.pop_front() : 8'hFF;
    exp_rx.push_back(mo);
    n_chk++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL miso_word mode%0d: got %02h expected %02h", m, mi, e);
    end
  endtask

  task automatic drain(input int m, input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'h00;
      n_chk++;
      if (rx_vld[m] !== 1'b1 || rx_dout[m] !== e) begin
        n_fail++;
        $display("FAIL rx_word mode%0d #%0d: got vld=%b %02h expected vld=1 %02h",
                 m, k, rx_vld[m], rx_dout[m], e);
      end
      rx_rdy[m] = 1'b1;
      @(negedge clk);
      rx_rdy[m] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #20;
    for (int m = 0; m < 4; m++) begin
      n_chk++;
      if ({miso[m], miso_oe[m], tx_rdy[m], rx_vld[m], rx_ovf[m], tx_udf[m]} !== 6'b001000) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: got %b expected 001000", m,
                 {miso[m], miso_oe[m], tx_rdy[m], rx_vld[m], rx_ovf[m], tx_udf[m]});
      end
      n_chk++;
      if (rx_dout[m] !== 8'h00 || tx_level[m] !== 5'd0 || rx_level[m] !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: got dout=%h tl=%0d rl=%0d expected 0 0 0",
                 m, rx_dout[m], tx_level[m], rx_level[m]);
      end
    end
    rst_n = 1'b1;
    #40;
  endtask

  task automatic test_mode0;
    push_tx(0, 8'hA5);
    cs_low(0);
    n_chk++;
    if (miso_oe[0] !== 1'b1 || tx_udf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_load: got oe=%b udf=%b expected oe=1 udf=0", miso_oe[0], tx_udf[0]);
    end
    spi_word(0, 8'h3C);
    cs_high(0);
    n_chk++;
    if (miso_oe[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_oe_off: got %b expected 0", miso_oe[0]);
    end
    drain(0, 1);
    pulse_clr(0);
    n_chk++;
    if (tx_udf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_clr: got udf=%b expected 0", tx_udf[0]);
    end
  endtask

  task automatic test_modes;
    for (int m = 1; m < 4; m++) begin
      push_tx(m, 8'h81);
      cs_low(m);
      n_chk++;
      if (tx_udf[m] !== 1'b0 || tx_level[m] !== 5'd0) begin
        n_fail++;
        $display("FAIL mode%0d_load: got udf=%b tl=%0d expected 0 0", m, tx_udf[m], tx_level[m]);
      end
      spi_word(m, 8'h7E);
      cs_high(m);
      drain(m, 1);
      pulse_clr(m);
    end
  endtask

  task automatic test_back_to_back;
    push_tx(0, 8'h11);
    push_tx(0, 8'h22);
    exp_mi.push_back(8'hFF);
    cs_low(0);
    spi_word(0, 8'hA1);
    spi_word(0, 8'hB2);
    spi_word(0, 8'hC3);
    cs_high(0);
    n_chk++;
    if (tx_udf[0] !== 1'b1 || rx_level[0] !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_status: got udf=%b rl=%0d expected udf=1 rl=3", tx_udf[0], rx_level[0]);
    end
    drain(0, 3);
    pulse_clr(0);
    n_chk++;
    if (tx_udf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_clr: got udf=%b expected 0", tx_udf[0]);
    end
  endtask

  task automatic test_overflow;
    cs_low(0);
    for (int k = 0; k < 17; k++) begin
      exp_mi.push_back(8'hFF);
      spi_word(0, 8'(k * 13 + 5));
    end
    cs_high(0);
    void'(exp_rx.pop_back());
    n_chk++;
    if (rx_level[0] !== 5'd16 || rx_ovf[0] !== 1'b1 || rx_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_status: got rl=%0d ovf=%b vld=%b expected 16 1 1",
               rx_level[0], rx_ovf[0], rx_vld[0]);
    end
    pulse_clr(0);
    n_chk++;
    if (rx_ovf[0] !== 1'b0 || tx_udf[0] !== 1'b0 || rx_level[0] !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_clr: got ovf=%b udf=%b rl=%0d expected 0 0 16",
               rx_ovf[0], tx_udf[0], rx_level[0]);
    end
    drain(0, 16);
    n_chk++;
    if (rx_vld[0] !== 1'b0 || rx_level[0] !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_empty: got vld=%b rl=%0d expected 0 0", rx_vld[0], rx_level[0]);
    end
  endtask

  task automatic test_abort;
    logic [7:0] mi, e;
    push_tx(0, 8'h96);
    cs_low(0);
    xfer(0, 8'hF0, 5, mi);
    e = exp_mi.pop_front();
    n_chk++;
    if (mi[7:3] !== e[7:3]) begin
      n_fail++;
      $display("FAIL abort_bits: got %b expected %b", mi[7:3], e[7:3]);
    end
    cs_high(0);
    n_chk++;
    if (rx_level[0] !== 5'd0 || rx_vld[0] !== 1'b0 || tx_level[0] !== 5'd0 || miso_oe[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got rl=%0d vld=%b tl=%0d oe=%b expected 0 0 0 0",
               rx_level[0], rx_vld[0], tx_level[0], miso_oe[0]);
    end
    push_tx(0, 8'h69);
    cs_low(0);
    spi_word(0, 8'hC3);
    cs_high(0);
    drain(0, 1);
    pulse_clr(0);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] mi;
    push_tx(0, 8'h12);
    push_tx(0, 8'h34);
    cs_low(0);
    xfer(0, 8'hFF, 3, mi);
    rst_n = 1'b0;
    #20;
    for (int m = 0; m < 4; m++) begin
      n_chk++;
      if ({miso[m], miso_oe[m], tx_rdy[m], rx_vld[m], rx_ovf[m], tx_udf[m]} !== 6'b001000) begin
        n_fail++;
        $display("FAIL midrst_flags dut%0d: got %b expected 001000", m,
                 {miso[m], miso_oe[m], tx_rdy[m], rx_vld[m], rx_ovf[m], tx_udf[m]});
      end
      n_chk++;
      if (rx_dout[m] !== 8'h00 || tx_level[m] !== 5'd0 || rx_level[m] !== 5'd0) begin
        n_fail++;
        $display("FAIL midrst_data dut%0d: got dout=%h tl=%0d rl=%0d expected 0 0 0",
                 m, rx_dout[m], tx_level[m], rx_level[m]);
      end
    end
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    exp_mi.delete();
    exp_rx.delete();
    #20;
    rst_n = 1'b1;
    #200;
    n_chk++;
    if (tx_level[0] !== 5'd0 || miso_oe[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got tl=%0d oe=%b expected 0 0", tx_level[0], miso_oe[0]);
    end
    push_tx(0, 8'h5A);
    cs_low(0);
    spi_word(0, 8'hE7);
    cs_high(0);
    drain(0, 1);
  endtask

  initial begin
    sclk = 4'b1100;
    cs_n = '1;
    mosi = '0;
    tx_vld = '0;
    rx_rdy = '0;
    clr_err = '0;
    tx_din = '0;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end
endmodule
